// File: rtl/exe_branch_resolve.sv
// rtl/exe_branch_resolve.sv - branch resolution stage: prediction queue, mispredict redirect, illegal-branch exception
//
// Optional feature macro: BRANCH_RESOLVE_STATS_EN (adds stat_branches / stat_mispred counters)
//
// Ports:
//   CLK, RST_N                       clock (rising edge), asynchronous active-low reset
//   pred_valid/pred_ready            fetch-time prediction push handshake
//   pred_taken/pred_target/pred_tag  predicted direction, target and branch tag
//   res_valid/res_ready              comparator resolve handshake
//   res_taken/res_target             actual direction and computed target
//   res_next_pc                      correct next PC used for a redirect
//   res_invalid/res_tag              undefined branch encoding flag, tag of resolved branch
//   redir_valid/redir_ready/redir_pc redirect request to fetch
//   exc_valid/exc_tag                one-cycle illegal-branch exception pulse and its tag
//   seq_err                          sticky: resolved tag differed from queue head tag
//   stat_branches/stat_mispred       (stats build only) resolve and mispredict counters
module exe_branch_resolve #(
  parameter int ADDR_W = 40,
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 3
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              pred_valid,
  output logic              pred_ready,
  input  logic              pred_taken,
  input  logic [ADDR_W-1:0] pred_target,
  input  logic [TAG_W-1:0]  pred_tag,
  input  logic              res_valid,
  output logic              res_ready,
  input  logic              res_taken,
  input  logic [ADDR_W-1:0] res_target,
  input  logic [ADDR_W-1:0] res_next_pc,
  input  logic              res_invalid,
  input  logic [TAG_W-1:0]  res_tag,
  output logic              redir_valid,
  input  logic              redir_ready,
  output logic [ADDR_W-1:0] redir_pc,
  output logic              exc_valid,
  output logic [TAG_W-1:0]  exc_tag,
`ifdef BRANCH_RESOLVE_STATS_EN
  output logic [31:0]       stat_branches,
  output logic [31:0]       stat_mispred,
`endif
  output logic              seq_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_REDIR = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic              q_taken  [DEPTH];
  logic [ADDR_W-1:0] q_target [DEPTH];
  logic [TAG_W-1:0]  q_tag    [DEPTH];

  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;

  logic              push_fire, res_fire;
  logic              head_taken;
  logic [ADDR_W-1:0] head_target;
  logic [TAG_W-1:0]  head_tag;
  logic              mispred;
  logic              take_redir;
  logic              take_exc;
  logic              flush;

  // Handshakes depend only on registered state so no input-to-output path exists.
  assign pred_ready = (state_q == ST_RUN) && (count < CNT_W'(DEPTH));
  assign res_ready  = (state_q == ST_RUN) && (count != '0);

  assign push_fire = pred_valid && pred_ready;
  assign res_fire  = res_valid && res_ready;

  assign head_taken  = q_taken[rd_ptr];
  assign head_target = q_target[rd_ptr];
  assign head_tag    = q_tag[rd_ptr];

  // Target only matters when the branch was actually taken.
  assign mispred    = (head_taken != res_taken) || (res_taken && (head_target != res_target));
  // An illegal encoding is reported as an exception and never redirects.
  assign take_exc   = res_fire && res_invalid;
  assign take_redir = res_fire && !res_invalid && mispred;
  // Both cases discard every younger prediction, including one pushed this cycle.
  assign flush      = take_exc || take_redir;

  assign redir_valid = (state_q == ST_REDIR);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (take_redir) state_d = ST_REDIR;
      ST_REDIR: if (redir_ready) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + PTR_W'(1);
      if (res_fire)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_fire, res_fire})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read while count says they are live.
  always_ff @(posedge CLK) begin
    if (push_fire && !flush) begin
      q_taken[wr_ptr]  <= pred_taken;
      q_target[wr_ptr] <= pred_target;
      q_tag[wr_ptr]    <= pred_tag;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      redir_pc  <= '0;
      exc_valid <= 1'b0;
      exc_tag   <= '0;
      seq_err   <= 1'b0;
    end else begin
      if (take_redir) redir_pc <= res_next_pc;
      exc_valid <= take_exc;
      if (take_exc) exc_tag <= res_tag;
      if (res_fire && (res_tag != head_tag)) seq_err <= 1'b1;
    end
  end

`ifdef BRANCH_RESOLVE_STATS_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stat_branches <= '0;
      stat_mispred  <= '0;
    end else begin
      if (res_fire)   stat_branches <= stat_branches + 32'd1;
      if (take_redir) stat_mispred  <= stat_mispred + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_exe_branch_resolve.sv
// tb/tb_exe_branch_resolve.sv - table-driven bench for exe_branch_resolve
module tb_exe_branch_resolve;

  logic        CLK;
  logic        RST_N;
  logic        pred_valid, pred_ready, pred_taken;
  logic [39:0] pred_target;
  logic [2:0]  pred_tag;
  logic        res_valid, res_ready, res_taken, res_invalid;
  logic [39:0] res_target, res_next_pc;
  logic [2:0]  res_tag;
  logic        redir_valid, redir_ready;
  logic [39:0] redir_pc;
  logic        exc_valid;
  logic [2:0]  exc_tag;
  logic        seq_err;
`ifdef BRANCH_RESOLVE_STATS_EN
  logic [31:0] stat_branches, stat_mispred;
`endif

  exe_branch_resolve #(.ADDR_W(40), .DEPTH(4), .TAG_W(3)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .pred_valid(pred_valid), .pred_ready(pred_ready), .pred_taken(pred_taken),
    .pred_target(pred_target), .pred_tag(pred_tag),
    .res_valid(res_valid), .res_ready(res_ready), .res_taken(res_taken),
    .res_target(res_target), .res_next_pc(res_next_pc), .res_invalid(res_invalid),
    .res_tag(res_tag),
    .redir_valid(redir_valid), .redir_ready(redir_ready), .redir_pc(redir_pc),
    .exc_valid(exc_valid), .exc_tag(exc_tag),
`ifdef BRANCH_RESOLVE_STATS_EN
    .stat_branches(stat_branches), .stat_mispred(stat_mispred),
`endif
    .seq_err(seq_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        pv, pt;
    logic [39:0] ptgt;
    logic [2:0]  ptag;
    logic        rv, rt;
    logic [39:0] rtgt, rnext;
    logic        rinv;
    logic [2:0]  rtag;
    logic        rr;
    logic        e_pr, e_rs, e_rv;
    logic [39:0] e_rpc;
    logic        e_ev;
    logic [2:0]  e_et;
    logic        e_se;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s vec %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
  endtask

  task automatic v(input logic pv, input logic pt, input logic [39:0] ptgt, input logic [2:0] ptag,
                   input logic rv, input logic rt, input logic [39:0] rtgt, input logic [39:0] rnext,
                   input logic rinv, input logic [2:0] rtag, input logic rr,
                   input logic e_pr, input logic e_rs, input logic e_rv, input logic [39:0] e_rpc,
                   input logic e_ev, input logic [2:0] e_et, input logic e_se);
    vec_t x;
    x.pv = pv; x.pt = pt; x.ptgt = ptgt; x.ptag = ptag;
    x.rv = rv; x.rt = rt; x.rtgt = rtgt; x.rnext = rnext; x.rinv = rinv; x.rtag = rtag;
    x.rr = rr;
    x.e_pr = e_pr; x.e_rs = e_rs; x.e_rv = e_rv; x.e_rpc = e_rpc;
    x.e_ev = e_ev; x.e_et = e_et; x.e_se = e_se;
    tbl.push_back(x);
  endtask

  task automatic idle_inputs();
    pred_valid = 0; pred_taken = 0; pred_target = '0; pred_tag = '0;
    res_valid = 0; res_taken = 0; res_target = '0; res_next_pc = '0; res_invalid = 0; res_tag = '0;
    redir_ready = 0;
  endtask

  initial begin
    idle_inputs();
    RST_N = 1'b0;

    // Two not-taken branches resolved correctly
    v(1,0,40'h0,0,    0,0,40'h0,40'h0,0,0, 0,  1,1,0,40'h0,0,0,0);
    v(1,0,40'h0,1,    0,0,40'h0,40'h0,0,0, 0,  1,1,0,40'h0,0,0,0);
    v(0,0,40'h0,0,    1,0,40'h0,40'h4,0,0, 0,  1,1,0,40'h0,0,0,0);
    v(0,0,40'h0,0,    1,0,40'h0,40'h8,0,1, 0,  1,0,0,40'h0,0,0,0);
    // Taken with wrong target -> redirect held while fetch stalls
    v(1,1,40'h1000,2, 0,0,40'h0,40'h0,0,0, 0,  1,1,0,40'h0,0,0,0);
    v(0,0,40'h0,0,    1,1,40'h1040,40'h1040,0,2, 0, 0,0,1,40'h1040,0,0,0);
    v(1,0,40'h0,3,    1,0,40'h0,40'h0,0,3, 0,  0,0,1,40'h1040,0,0,0);
    v(1,0,40'h0,3,    0,0,40'h0,40'h0,0,0, 0,  0,0,1,40'h1040,0,0,0);
    v(1,0,40'h0,3,    0,0,40'h0,40'h0,0,0, 0,  0,0,1,40'h1040,0,0,0);
    v(0,0,40'h0,0,    0,0,40'h0,40'h0,0,0, 1,  1,0,0,40'h0,0,0,0);
    // Fill to full, then push+resolve on full: push refused
    v(1,0,40'h0,4,    0,0,40'h0,40'h0,0,0, 0,  1,1,0,40'h0,0,0,0);
    v(1,0,40'h0,5,    0,0,40'h0,40'h0,0,0, 0,  1,1,0,40'h0,0,0,0);
    v(1,0,40'h0,6,    0,0,40'h0,40'h0,0,0, 0,  1,1,0,40'h0,0,0,0);
    v(1,0,40'h0,7,    0,0,40'h0,40'h0,0,0, 0,  0,1,0,40'h0,0,0,0);
    v(1,0,40'h0,0,    1,0,40'h0,40'h4,0,4, 0,  1,1,0,40'h0,0,0,0);
    v(0,0,40'h0,0,    1,0,40'h0,40'h4,0,5, 0,  1,1,0,40'h0,0,0,0);
    v(0,0,40'h0,0,    1,0,40'h0,40'h4,0,6, 0,  1,1,0,40'h0,0,0,0);
    v(0,0,40'h0,0,    1,0,40'h0,40'h4,0,7, 0,  1,0,0,40'h0,0,0,0);
    // Predicted not-taken, actually taken
    v(1,0,40'h0,0,    0,0,40'h0,40'h0,0,0, 0,  1,1,0,40'h0,0,0,0);
    v(0,0,40'h0,0,    1,1,40'h2000,40'h2000,0,0, 0, 0,0,1,40'h2000,0,0,0);
    v(0,0,40'h0,0,    0,0,40'h0,40'h0,0,0, 1,  1,0,0,40'h0,0,0,0);
    // Predicted taken, actually not-taken
    v(1,1,40'h3000,1, 0,0,40'h0,40'h0,0,0, 1,  1,1,0,40'h0,0,0,0);
    v(0,0,40'h0,0,    1,0,40'h3000,40'h2008,0,1, 1, 0,0,1,40'h2008,0,0,0);
    v(0,0,40'h0,0,    0,0,40'h0,40'h0,0,0, 1,  1,0,0,40'h0,0,0,0);
    // Pointer wrap: 10 correct predictions, push and resolve overlapped
    for (int i = 0; i < 10; i++) begin
      logic [2:0]  t;
      logic [2:0]  tp;
      logic [39:0] tg, tgp;
      t   = 3'(i);
      tp  = 3'(i - 1);
      tg  = 40'(i * 'h100);
      tgp = 40'((i - 1) * 'h100);
      if (i == 0)
        v(1,1,tg,t, 0,0,40'h0,40'h0,0,0, 0, 1,1,0,40'h0,0,0,0);
      else
        v(1,(i % 2) == 0,tg,t, 1,((i - 1) % 2) == 0,tgp,40'h0,0,tp, 0, 1,1,0,40'h0,0,0,0);
    end
    v(0,0,40'h0,0,    1,0,40'h0,40'h0,0,1, 0,  1,0,0,40'h0,0,0,0);
    // Illegal branch: exception pulse, queue flushed, coinciding push dropped
    v(1,0,40'h0,5,    0,0,40'h0,40'h0,0,0, 0,  1,1,0,40'h0,0,0,0);
    v(1,0,40'h0,6,    0,0,40'h0,40'h0,0,0, 0,  1,1,0,40'h0,0,0,0);
    v(1,0,40'h0,7,    1,1,40'h5000,40'h5000,1,5, 0, 1,0,0,40'h0,1,5,0);
    v(0,0,40'h0,0,    0,0,40'h0,40'h0,0,0, 0,  1,0,0,40'h0,0,0,0);
    // Tag mismatch: seq_err sticky
    v(1,0,40'h0,4,    0,0,40'h0,40'h0,0,0, 0,  1,1,0,40'h0,0,0,0);
    v(0,0,40'h0,0,    1,0,40'h0,40'h0,0,3, 0,  1,0,0,40'h0,0,0,1);
    v(0,0,40'h0,0,    0,0,40'h0,40'h0,0,0, 0,  1,0,0,40'h0,0,0,1);
    v(1,0,40'h0,2,    0,0,40'h0,40'h0,0,0, 0,  1,1,0,40'h0,0,0,1);
    v(0,0,40'h0,0,    1,0,40'h0,40'h0,0,2, 0,  1,0,0,40'h0,0,0,1);

    // Reset values
    #1;
    chk("rst_pred_ready", -1, pred_ready, 1);
    chk("rst_res_ready", -1, res_ready, 0);
    chk("rst_redir_valid", -1, redir_valid, 0);
    chk("rst_redir_pc", -1, redir_pc, 0);
    chk("rst_exc_valid", -1, exc_valid, 0);
    chk("rst_exc_tag", -1, exc_tag, 0);
    chk("rst_seq_err", -1, seq_err, 0);
`ifdef BRANCH_RESOLVE_STATS_EN
    chk("rst_stat_branches", -1, stat_branches, 0);
    chk("rst_stat_mispred", -1, stat_mispred, 0);
`endif
    @(negedge CLK);
    RST_N = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge CLK);
      pred_valid = tbl[i].pv; pred_taken = tbl[i].pt; pred_target = tbl[i].ptgt; pred_tag = tbl[i].ptag;
      res_valid = tbl[i].rv; res_taken = tbl[i].rt; res_target = tbl[i].rtgt;
      res_next_pc = tbl[i].rnext; res_invalid = tbl[i].rinv; res_tag = tbl[i].rtag;
      redir_ready = tbl[i].rr;
      @(posedge CLK);
      #1;
      chk("pred_ready", i, pred_ready, tbl[i].e_pr);
      chk("res_ready", i, res_ready, tbl[i].e_rs);
      chk("redir_valid", i, redir_valid, tbl[i].e_rv);
      if (tbl[i].e_rv) chk("redir_pc", i, redir_pc, tbl[i].e_rpc);
      chk("exc_valid", i, exc_valid, tbl[i].e_ev);
      if (tbl[i].e_ev) chk("exc_tag", i, exc_tag, tbl[i].e_et);
      chk("seq_err", i, seq_err, tbl[i].e_se);
    end

    // Asynchronous reset while a redirect is pending
    @(negedge CLK);
    idle_inputs();
    pred_valid = 1; pred_taken = 1; pred_target = 40'h10; pred_tag = 0;
    @(negedge CLK);
    idle_inputs();
    res_valid = 1; res_taken = 0; res_next_pc = 40'h8; res_tag = 0;
    @(posedge CLK);
    #1;
    idle_inputs();
    chk("pre_rst_redir_valid", -2, redir_valid, 1);
    chk("pre_rst_redir_pc", -2, redir_pc, 40'h8);
    #1;
    RST_N = 1'b0;
    #1;
    chk("async_rst_redir_valid", -2, redir_valid, 0);
    chk("async_rst_seq_err", -2, seq_err, 0);
    chk("async_rst_res_ready", -2, res_ready, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    chk("post_rst_pred_ready", -2, pred_ready, 1);
    chk("post_rst_res_ready", -2, res_ready, 0);
    chk("post_rst_redir_valid", -2, redir_valid, 0);
`ifdef BRANCH_RESOLVE_STATS_EN
    chk("post_rst_stat_branches", -2, stat_branches, 0);
    chk("post_rst_stat_mispred", -2, stat_mispred, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/exe_branch_resolve.md
# exe_branch_resolve

Branch resolution stage directly downstream of the execute-stage branch comparator. Holds a small in-order queue of fetch-time predictions, pops the head when the comparator reports a resolved branch, and compares the actual outcome and target against the prediction. On a mispredict it flushes all younger predictions and drives a redirect PC to fetch over a valid/ready handshake. An undefined branch encoding raises an exception pulse instead of a redirect.

## Interface
Parameters:
- ADDR_W, 40, PC/target width
- DEPTH, 4, prediction queue entries (power of two, ≥2)
- TAG_W, 3, branch tag width

Ports:
- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- pred_valid  in  1  fetch pushes a prediction
- pred_ready  out  1  queue can accept a push
- pred_taken  in  1  predicted direction
- pred_target  in  ADDR_W  predicted target
- pred_tag  in  TAG_W  tag of predicted branch
- res_valid  in  1  comparator result valid
- res_ready  out  1  resolve accepted
- res_taken  in  1  actual direction
- res_target  in  ADDR_W  computed branch target
- res_next_pc  in  ADDR_W  correct next PC (target if taken, else PC+4)
- res_invalid  in  1  undefined funct3 on branch
- res_tag  in  TAG_W  tag of resolved branch
- redir_valid  out  1  redirect request to fetch
- redir_ready  in  1  fetch accepts redirect
- redir_pc  out  ADDR_W  redirect PC
- exc_valid  out  1  one-cycle illegal-branch exception pulse
- exc_tag  out  TAG_W  tag of illegal branch
- seq_err  out  1  sticky: resolve tag ≠ head tag

## Operation
- Queue: circular FIFO, rd/wr pointers log2(DEPTH) bits wrapping modulo DEPTH, count log2(DEPTH)+1 bits.
- Push fires when pred_valid && pred_ready; pred_ready = (state==RUN) && (count<DEPTH). No bypass: full queue refuses push even if pop same cycle.
- Resolve fires when res_valid && res_ready; res_ready = (state==RUN) && (count>0).
- On resolve fire: pop head. If res_tag ≠ head tag, set seq_err (cleared only by reset); evaluation proceeds.
- res_invalid=1: exc_valid=1 next cycle, exc_tag=res_tag; queue cleared; state stays RUN; no redirect.
- Mispredict = (pred_taken ≠ res_taken) || (res_taken && pred_target ≠ res_target). On mispredict: queue cleared (count=0, pointers=0), redir_pc ← res_next_pc, state → REDIR.
- Correct prediction: pop only.
- Push coinciding with a clearing resolve (mispredict or invalid) is dropped: younger than the flushing branch.
- States: RUN (normal); REDIR (redir_valid=1, redir_pc stable, pred_ready=res_ready=0). REDIR → RUN on cycle where redir_ready=1.
- Simultaneous non-clearing push and pop: count unchanged, both pointers advance.

## Timing
- Reset values: pred_ready=1, res_ready=0, redir_valid=0, redir_pc=0, exc_valid=0, exc_tag=0, seq_err=0; state RUN; queue empty.
- Resolve-to-redirect latency: 1 cycle (redir_valid registered). Redirect held until handshake; first cycle of RUN after handshake accepts pushes.
- exc_valid: exactly one cycle, 1 cycle after resolve.
- Reset asserted mid-REDIR: redir_valid drops asynchronously to 0, queue empty.
- All handshake outputs (pred_ready, res_ready) combinational from registered state/count only; no combinational path from inputs.

## Configuration
- BRANCH_RESOLVE_STATS_EN defined: adds outputs stat_branches (32) and stat_mispred (32), counters reset to 0, incremented per resolve fire / per mispredict (invalid counts as branch, not mispredict), wrap at 2^32.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Test plan
- Push tags 0,1 (not-taken), resolve tag 0 not-taken, tag 1 not-taken -> no redir_valid, count 0, res_ready=0 after.
- Push tag 2 taken target 0x1000; resolve taken target 0x1040, next_pc 0x1040 -> redir_valid next cycle, redir_pc=0x1040; hold redir_ready=0 for 3 cycles -> redir_valid, redir_pc stable, pred_ready=0; redir_ready=1 -> RUN.
- Fill DEPTH=4 entries -> pred_ready=0; push+resolve same cycle on full -> push refused, count 3.
- Pointer wrap: 10 push/resolve pairs interleaved, all correct -> no redirect, seq_err=0.
- Resolve with res_invalid=1 tag 5 -> exc_valid one cycle, exc_tag=5, queue cleared; resolve with res_tag 3 vs head 4 -> seq_err=1 sticky.
- Assert RST_N low during REDIR -> redir_valid=0 immediately, pred_ready=1 after release; with STATS_EN, counters read 0.
